// File: rtl/bcd_to_binary_if.sv
// Handshake and result bundle for the sequential BCD-to-binary converter.
// The master issues start/digits; the slave returns status and the held result.
interface bcd_to_binary_if #(
    parameter int SIZE        = 8,
    parameter int DIGIT_COUNT = 3
);
    logic                       start;
    logic [4*DIGIT_COUNT-1:0]   digits;
    logic                       busy;
    logic                       done;
    logic [SIZE-1:0]            data;
    logic                       overflow;
    logic                       invalid;

    modport master (
        output start, digits,
        input  busy, done, data, overflow, invalid
    );

    modport slave (
        input  start, digits,
        output busy, done, data, overflow, invalid
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double dabble: one right
// shift plus per-digit correction per clock, 4*DIGIT_COUNT iterations.
module bcd_to_binary #(
    parameter int SIZE        = 8,
    parameter int DIGIT_COUNT = 3
) (
    input  logic           clk,
    input  logic           reset,
    bcd_to_binary_if.slave bus
);
    localparam int W    = 4 * DIGIT_COUNT;
    localparam int CW   = $clog2(4 * DIGIT_COUNT + 1);
    localparam int XW   = (SIZE > W) ? SIZE : W;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_r;
    logic [W-1:0]      bcd_r;
    logic [W-1:0]      bin_r;
    logic [CW-1:0]     cnt_r;
    logic              inv_r;
    logic              busy_r;
    logic              done_r;
    logic [SIZE-1:0]   data_r;
    logic              overflow_r;
    logic              invalid_r;

    logic [2*W-1:0]    shifted_s;
    logic [W-1:0]      next_bcd_s;
    logic [W-1:0]      next_bin_s;
    logic [XW-1:0]     ext_bin_s;
    logic              next_ovf_s;

    // Undo the doubling that a left-shifting encoder would have applied.
    function automatic logic [3:0] dabble_fix(input logic [3:0] dig);
        logic [3:0] res;
        if (dig >= 4'd8) begin
            res = dig - 4'd3;
        end else begin
            res = dig;
        end
        return res;
    endfunction

    function automatic logic any_digit_invalid(input logic [W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            bad = bad | (d[4*i+3] & (d[4*i+2] | d[4*i+1]));
        end
        return bad;
    endfunction

    // One iteration: shift the concatenated pair right, then correct each BCD digit.
    always_comb begin
        shifted_s  = {bcd_r, bin_r} >> 1;
        next_bcd_s = '0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            next_bcd_s[4*i +: 4] = dabble_fix(shifted_s[W + 4*i +: 4]);
        end
        next_bin_s = shifted_s[W-1:0];
        ext_bin_s  = XW'(next_bin_s);
        next_ovf_s = |(next_bin_s >> SIZE);
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            bcd_r      <= '0;
            bin_r      <= '0;
            cnt_r      <= '0;
            inv_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            data_r     <= '0;
            overflow_r <= 1'b0;
            invalid_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        bcd_r   <= bus.digits;
                        bin_r   <= '0;
                        inv_r   <= any_digit_invalid(bus.digits);
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_r <= next_bcd_s;
                    bin_r <= next_bin_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= IDLE;
                        invalid_r <= inv_r;
                        // Non-decimal input yields a zero result rather than garbage.
                        if (inv_r) begin
                            data_r     <= '0;
                            overflow_r <= 1'b0;
                        end else begin
                            data_r     <= ext_bin_s[SIZE-1:0];
                            overflow_r <= next_ovf_s;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.data     = data_r;
    assign bus.overflow = overflow_r;
    assign bus.invalid  = invalid_r;
endmodule
